iic_mem_arbiter: RTL and testbench

- Shares one single-port register memory (1-cycle read latency) between the IIC slave's memory-mapped master port and NUM_LOCAL local requesters.
- The IIC port has absolute priority and is never stalled, because the IIC slave issues single-cycle read/write pulses and samples read data exactly one cycle after its read pulse.
- Local requesters use a req/gnt handshake, are served round-robin, and can take an exclusive lock for read-modify-write sequences.

---
 rtl/iic_arb_pkg.sv | 19 +
 rtl/iic_mem_arbiter_if.sv | 55 +++++
 rtl/iic_mem_arbiter_rr_pick.sv | 31 +++
 rtl/iic_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_iic_mem_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/iic_arb_pkg.sv
// Shared types for the IIC/local memory arbiter: lock FSM states, read-return tag, index width.
package iic_arb_pkg;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    // Wide enough for up to 8 local requesters.
    localparam int unsigned TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic                 is_local;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iic_mem_arbiter_if.sv
// Bus bundle for the arbiter: IIC master port, local requesters, memory port and lock status.
interface iic_mem_arbiter_if
    import iic_arb_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned NUM_LOCAL = 2
);
    localparam int unsigned IdxW = idx_w(NUM_LOCAL);

    logic [AW-1:0]           a_address;
    logic [DW-1:0]           a_writedata;
    logic                    a_write;
    logic                    a_read;
    logic [DW-1:0]           a_readdata;

    logic [NUM_LOCAL-1:0]    l_req;
    logic [NUM_LOCAL-1:0]    l_we;
    logic [NUM_LOCAL-1:0]    l_lock;
    logic [NUM_LOCAL*AW-1:0] l_addr;
    logic [NUM_LOCAL*DW-1:0] l_wdata;
    logic [NUM_LOCAL-1:0]    l_gnt;
    logic [NUM_LOCAL-1:0]    l_rvalid;
    logic [DW-1:0]           l_rdata;

    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic                    mem_we;
    logic                    mem_re;
    logic [DW-1:0]           mem_rdata;

    logic                    locked;
    logic [IdxW-1:0]         lock_owner;

    modport slave (
        input  a_address, a_writedata, a_write, a_read,
        output a_readdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata,
        output locked, lock_owner
    );

    modport master (
        output a_address, a_writedata, a_write, a_read,
        input  a_readdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata,
        input  locked, lock_owner
    );

endinterface

// File: rtl/iic_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW:0] w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = {1'b0, i_start} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) w_pos = w_pos - (IW+1)'(N);
            if (!o_valid && i_req[w_pos[IW-1:0]]) begin
                o_valid               = 1'b1;
                o_idx                 = w_pos[IW-1:0];
                o_gnt[w_pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_mem_arbiter.sv
// Single-port memory arbiter: IIC port has absolute priority, locals are round-robin with
// an optional exclusive lock for read-modify-write sequences.
module iic_mem_arbiter
    import iic_arb_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned NUM_LOCAL = 2
) (
    input  logic               clk,
    input  logic               rst,
    iic_mem_arbiter_if.slave   bus
);

    localparam int unsigned IdxW = idx_w(NUM_LOCAL);

    lock_state_e          r_state;
    logic [IdxW-1:0]      r_owner;
    logic [IdxW-1:0]      r_rr_ptr;
    rd_tag_t              r_tag;
    logic [AW-1:0]        r_last_addr;
    logic [DW-1:0]        r_last_wdata;

    logic                 w_iic_act;
    logic [NUM_LOCAL-1:0] w_owner_mask;
    logic [NUM_LOCAL-1:0] w_elig;
    logic [NUM_LOCAL-1:0] w_pick_gnt;
    logic [IdxW-1:0]      w_pick_idx;
    logic [IdxW-1:0]      w_next_ptr;
    logic                 w_pick_any;
    logic                 w_lgrant;

    assign w_iic_act = bus.a_write | bus.a_read;

    always_comb begin
        w_owner_mask          = '0;
        w_owner_mask[r_owner] = 1'b1;
    end

    assign w_elig = (r_state == LOCKED) ? (bus.l_req & w_owner_mask) : bus.l_req;

    rr_pick #(
        .N  (NUM_LOCAL),
        .IW (IdxW)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_start (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_any)
    );

    // Locals only win cycles the IIC port leaves idle; a pre-empted requester simply retries.
    assign w_lgrant   = ~rst & ~w_iic_act & w_pick_any;
    assign w_next_ptr = (w_pick_idx == IdxW'(NUM_LOCAL - 1)) ? '0 : w_pick_idx + 1'b1;

    always_comb begin
        bus.l_gnt     = w_lgrant ? w_pick_gnt : '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = r_last_addr;
        bus.mem_wdata = r_last_wdata;
        if (!rst && w_iic_act) begin
            bus.mem_addr  = bus.a_address;
            bus.mem_wdata = bus.a_writedata;
            bus.mem_we    = bus.a_write;
            bus.mem_re    = bus.a_read & ~bus.a_write;
        end else if (w_lgrant) begin
            bus.mem_addr  = bus.l_addr[int'(w_pick_idx)*AW +: AW];
            bus.mem_wdata = bus.l_wdata[int'(w_pick_idx)*DW +: DW];
            bus.mem_we    = bus.l_we[w_pick_idx];
            bus.mem_re    = ~bus.l_we[w_pick_idx];
        end
    end

    always_comb begin
        bus.l_rvalid = '0;
        if (!rst && r_tag.valid && r_tag.is_local) bus.l_rvalid[r_tag.idx[IdxW-1:0]] = 1'b1;
    end

    // Memory has 1-cycle read latency, matching the IIC slave's sampling point.
    assign bus.l_rdata    = bus.mem_rdata;
    assign bus.a_readdata = bus.mem_rdata;
    assign bus.locked     = (r_state == LOCKED);
    assign bus.lock_owner = r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_tag        <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_tag.valid    <= bus.mem_re;
            r_tag.is_local <= w_lgrant;
            r_tag.idx      <= TAG_IDX_W'(w_pick_idx);
            if (w_lgrant) r_rr_ptr <= w_next_ptr;
            if (bus.mem_we || bus.mem_re) begin
                r_last_addr  <= bus.mem_addr;
                r_last_wdata <= bus.mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNLOCKED;
            r_owner <= '0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if (w_lgrant && bus.l_lock[w_pick_idx]) begin
                        r_state <= LOCKED;
                        r_owner <= w_pick_idx;
                    end
                end
                LOCKED: begin
                    if (!bus.l_lock[r_owner]) r_state <= UNLOCKED;
                end
                default: r_state <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_mem_arbiter.sv
// Directed table-driven bench for iic_mem_arbiter with a 1-cycle-latency memory model.
module tb_iic_mem_arbiter;

    logic clk;
    logic rst;

    iic_mem_arbiter_if #(.AW(8), .DW(8), .NUM_LOCAL(2)) bus ();

    iic_mem_arbiter #(
        .AW        (8),
        .DW        (8),
        .NUM_LOCAL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; contents preloaded whenever rst is high.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h40] <= 8'h11;
            mem[8'h41] <= 8'h22;
        end
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic       rst, aw, ar;
        logic [7:0] aa, ad;
        logic [1:0] req, we, lk;
        logic [7:0] la0, la1, wd0;
        logic [1:0] gnt;
        logic       mwe, mre;
        logic [7:0] maddr;
        logic [1:0] rv;
        logic       lkd, own, chk;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[$];
    int n_pass;
    int n_total;

    function automatic vec_t v(
        input logic rst, aw, ar, input logic [7:0] aa, ad,
        input logic [1:0] req, we, lk, input logic [7:0] la0, la1, wd0,
        input logic [1:0] gnt, input logic mwe, mre, input logic [7:0] maddr,
        input logic [1:0] rv, input logic lkd, own, chk, input logic [7:0] rd);
        vec_t x;
        x.rst = rst; x.aw = aw; x.ar = ar; x.aa = aa; x.ad = ad;
        x.req = req; x.we = we; x.lk = lk; x.la0 = la0; x.la1 = la1; x.wd0 = wd0;
        x.gnt = gnt; x.mwe = mwe; x.mre = mre; x.maddr = maddr;
        x.rv = rv; x.lkd = lkd; x.own = own; x.chk = chk; x.rd = rd;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic apply(input vec_t x);
        rst             = x.rst;
        bus.a_write     = x.aw;
        bus.a_read      = x.ar;
        bus.a_address   = x.aa;
        bus.a_writedata = x.ad;
        bus.l_req       = x.req;
        bus.l_we        = x.we;
        bus.l_lock      = x.lk;
        bus.l_addr      = {x.la1, x.la0};
        bus.l_wdata     = {8'h00, x.wd0};
    endtask

    task automatic idle();
        bus.a_write = 1'b0; bus.a_read = 1'b0; bus.a_address = '0; bus.a_writedata = '0;
        bus.l_req = '0; bus.l_we = '0; bus.l_lock = '0; bus.l_addr = '0; bus.l_wdata = '0;
    endtask

    initial begin
        bit got;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle();

        //            rst aw ar aa     ad     req   we    lk    la0    la1    wd0
        //            gnt   we re maddr  rv    lkd own chk rd
        vecs.push_back(v(1,0,1,8'h10,8'h00,2'b11,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b00,0,0,8'h00,2'b00,0,0,0,8'h00));              // reset gating
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,1,8'h10,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,1,8'h10,2'b00,0,0,0,8'h00));              // IIC read
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b00,0,0,1,8'hA5));
        vecs.push_back(v(0,1,0,8'h20,8'h77,2'b01,2'b01,2'b00,8'h20,8'h00,8'h33,
                         2'b00,1,0,8'h20,2'b00,0,0,0,8'h00));              // pre-empted
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b01,2'b01,2'b00,8'h20,8'h00,8'h33,
                         2'b01,1,0,8'h20,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,1,8'h20,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,1,8'h20,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b00,0,0,1,8'h33));
        vecs.push_back(v(0,1,1,8'h05,8'h5A,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,1,0,8'h05,2'b00,0,0,0,8'h00));              // write wins
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,1,8'h05,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,1,8'h05,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b00,0,0,1,8'h5A));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b10,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b10,0,1,8'h41,2'b00,0,0,0,8'h00));              // rr back to 0
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b01,0,1,8'h40,2'b10,0,0,1,8'h22));              // rr fairness
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b10,0,1,8'h41,2'b01,0,0,1,8'h11));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b01,0,1,8'h40,2'b10,0,0,1,8'h22));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b10,0,1,8'h41,2'b01,0,0,1,8'h11));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b10,0,0,1,8'h22));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b10,2'b00,2'b10,8'h40,8'h41,8'h00,
                         2'b10,0,1,8'h41,2'b00,0,0,0,8'h00));              // lock taken
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b10,8'h40,8'h41,8'h00,
                         2'b10,0,1,8'h41,2'b10,1,1,1,8'h22));
        vecs.push_back(v(0,0,1,8'h10,8'h00,2'b11,2'b00,2'b10,8'h40,8'h41,8'h00,
                         2'b00,0,1,8'h10,2'b10,1,1,1,8'h22));              // IIC while locked
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b10,8'h40,8'h41,8'h00,
                         2'b10,0,1,8'h41,2'b00,1,1,1,8'hA5));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b01,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b00,0,0,8'h00,2'b10,1,1,1,8'h22));              // lock released
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b01,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b01,0,1,8'h40,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b01,0,0,1,8'h11));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b01,2'b00,2'b01,8'h40,8'h41,8'h00,
                         2'b01,0,1,8'h40,2'b00,0,0,0,8'h00));              // owner 0 locks
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b01,2'b00,2'b01,8'h40,8'h41,8'h00,
                         2'b01,0,1,8'h40,2'b01,1,0,1,8'h11));
        vecs.push_back(v(1,0,0,8'h00,8'h00,2'b01,2'b00,2'b01,8'h40,8'h41,8'h00,
                         2'b00,0,0,8'h00,2'b00,1,0,0,8'h00));              // reset mid-lock
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b11,2'b00,2'b00,8'h40,8'h41,8'h00,
                         2'b01,0,1,8'h40,2'b00,0,0,0,8'h00));
        vecs.push_back(v(0,0,0,8'h00,8'h00,2'b00,2'b00,2'b00,8'h00,8'h00,8'h00,
                         2'b00,0,0,8'h00,2'b01,0,0,1,8'h11));

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d.gnt", i), 32'(bus.l_gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d.mem_we", i), 32'(bus.mem_we), 32'(vecs[i].mwe));
            check($sformatf("v%0d.mem_re", i), 32'(bus.mem_re), 32'(vecs[i].mre));
            check($sformatf("v%0d.rvalid", i), 32'(bus.l_rvalid), 32'(vecs[i].rv));
            check($sformatf("v%0d.locked", i), 32'(bus.locked), 32'(vecs[i].lkd));
            if (vecs[i].mwe || vecs[i].mre)
                check($sformatf("v%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].maddr));
            if (vecs[i].lkd || vecs[i].rst || i == 1)
                check($sformatf("v%0d.owner", i), 32'(bus.lock_owner), 32'(vecs[i].own));
            if (vecs[i].chk) begin
                check($sformatf("v%0d.a_readdata", i), 32'(bus.a_readdata), 32'(vecs[i].rd));
                check($sformatf("v%0d.l_rdata", i), 32'(bus.l_rdata), 32'(vecs[i].rd));
            end
            @(posedge clk);
            #1;
        end

        // Requester 1 alone: bounded wait for its grant, then the read return one cycle later.
        idle();
        rst        = 1'b0;
        bus.l_req  = 2'b10;
        bus.l_addr = {8'h41, 8'h40};
        got        = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (bus.l_gnt == 2'b10) got = 1'b1;
            @(posedge clk);
            #1;
        end
        check("seq.gnt_seen", 32'(got), 32'd1);
        bus.l_req = 2'b00;
        @(negedge clk);
        check("seq.rvalid", 32'(bus.l_rvalid), 32'h2);
        check("seq.rdata", 32'(bus.l_rdata), 32'h22);

        check("mem20_final", 32'(mem[8'h20]), 32'h33);
        check("mem05_final", 32'(mem[8'h05]), 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
